// File: rtl/ili9341_spi_stream.sv
// FIFO-buffered SPI write engine for ILI9341-class panels: hardware-reset sequencing,
// then MSB-first mode-0 streaming of 8/16-bit entries with CS held low across bursts.
module ili9341_spi_stream #(
    parameter int CLK_DIV         = 2,
    parameter int FIFO_DEPTH      = 16,
    parameter int RST_LOW_CYCLES  = 10000,
    parameter int RST_WAIT_CYCLES = 120000,
    parameter int CS_GAP_CYCLES   = 2
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   s_data,
    input  logic                          s_dc,
    input  logic                          s_wide,
    output logic                          init_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tft_rst,
    output logic                          tft_cs,
    output logic                          tft_dc,
    output logic                          tft_clk,
    output logic                          tft_din
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef struct packed {
        logic        dc;
        logic        wide;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        ST_RST_LOW, ST_RST_WAIT, ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP
    } state_t;

    entry_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop;

    state_t          state_q;
    logic [31:0]     cnt_q;
    logic [DW-1:0]   div_q;
    logic [3:0]      bits_q;
    logic [14:0]     sh_q;
    logic            rst_q, cs_q, dc_q, clk_q, din_q, done_q;

    entry_t          head;
    logic            head_msb;
    logic [14:0]     head_rest;

    assign head      = mem_q[rd_q];
    assign head_msb  = head.wide ? head.data[15] : head.data[7];
    assign head_rest = head.wide ? head.data[14:0] : {head.data[6:0], 8'h00};

    assign s_ready = (level_q != LW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == ST_LOAD);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is not reset: the pointers alone define what is valid.
    always_ff @(posedge sysclk) begin
        if (push) mem_q[wr_q] <= '{dc: s_dc, wide: s_wide, data: s_data};
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST_LOW;
            cnt_q   <= '0;
            div_q   <= '0;
            bits_q  <= '0;
            sh_q    <= '0;
            rst_q   <= 1'b0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            clk_q   <= 1'b0;
            din_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RST_LOW: begin
                    if (cnt_q == 32'(RST_LOW_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        rst_q   <= 1'b1;
                        state_q <= ST_RST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_RST_WAIT: begin
                    if (cnt_q == 32'(RST_WAIT_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if (level_q != '0) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    cs_q    <= 1'b0;
                    dc_q    <= head.dc;
                    din_q   <= head_msb;
                    sh_q    <= head_rest;
                    bits_q  <= head.wide ? 4'd15 : 4'd7;
                    div_q   <= '0;
                    clk_q   <= 1'b0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_q == DW'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!clk_q) begin
                            clk_q <= 1'b1;
                        end else begin
                            clk_q <= 1'b0;
                            if (bits_q != 4'd0) begin
                                bits_q <= bits_q - 4'd1;
                                din_q  <= sh_q[14];
                                sh_q   <= {sh_q[13:0], 1'b0};
                            end else if (level_q != '0) begin
                                // Next entry's first bit goes out on this falling edge;
                                // LOAD then pops it while SCK stays low.
                                dc_q    <= head.dc;
                                din_q   <= head_msb;
                                state_q <= ST_LOAD;
                            end else begin
                                cs_q    <= 1'b1;
                                cnt_q   <= '0;
                                state_q <= ST_GAP;
                            end
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 32'(CS_GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= ST_RST_LOW;
            endcase
        end
    end

    assign busy       = (level_q != '0) || (state_q inside {ST_LOAD, ST_SHIFT, ST_GAP});
    assign init_done  = done_q;
    assign fifo_level = level_q;
    assign tft_rst    = rst_q;
    assign tft_cs     = cs_q;
    assign tft_dc     = dc_q;
    assign tft_clk    = clk_q;
    assign tft_din    = din_q;
endmodule

// File: tb/tb_ili9341_spi_stream.sv
// Directed bench for ili9341_spi_stream: reset sequencing, single/burst transfers,
// FIFO full behaviour, mid-transfer reset and a randomised stream against a scoreboard.
module tb_ili9341_spi_stream;
    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_dc = 1'b0;
    logic        s_wide = 1'b0;
    logic        init_done, busy;
    logic [2:0]  fifo_level;
    logic        tft_rst, tft_cs, tft_dc, tft_clk, tft_din;

    always #5 sysclk = ~sysclk;

    ili9341_spi_stream #(
        .CLK_DIV(2), .FIFO_DEPTH(4), .RST_LOW_CYCLES(4),
        .RST_WAIT_CYCLES(8), .CS_GAP_CYCLES(2)
    ) dut (
        .sysclk(sysclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_dc(s_dc), .s_wide(s_wide), .init_done(init_done),
        .busy(busy), .fifo_level(fifo_level), .tft_rst(tft_rst), .tft_cs(tft_cs),
        .tft_dc(tft_dc), .tft_clk(tft_clk), .tft_din(tft_din)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Panel-side monitor: every SCK rise with CS low yields one {dc, din} sample.
    logic [1:0] rx_q [$];
    time        rise_t [$];
    int         sck_cs_hi = 0;
    int         cs_falls = 0;
    time        cs_rise_t = 0;
    time        min_gap = 1000000;
    bit         cs_seen_rise = 1'b0;

    always @(posedge tft_clk) begin
        if (tft_cs) sck_cs_hi++;
        else begin
            rx_q.push_back({tft_dc, tft_din});
            rise_t.push_back($time);
        end
    end
    always @(posedge tft_cs) begin
        cs_rise_t = $time;
        cs_seen_rise = 1'b1;
    end
    always @(negedge tft_cs) begin
        cs_falls++;
        if (cs_seen_rise && (($time - cs_rise_t) < min_gap)) min_gap = $time - cs_rise_t;
    end

    task automatic rx_take(input int nb, output logic [15:0] v, output logic [1:0] dcs);
        logic [1:0] b;
        v = '0;
        dcs = '0;
        if (rx_q.size() < nb) begin
            chk("rx_short", rx_q.size(), nb);
            return;
        end
        for (int i = 0; i < nb; i++) begin
            b = rx_q.pop_front();
            v = {v[14:0], b[0]};
            dcs[b[1]] = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge sysclk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Called on a negedge; the entry is accepted on the following posedge.
    task automatic drive(input logic [15:0] d, input logic dc, input logic w);
        s_valid = 1'b1;
        s_data  = d;
        s_dc    = dc;
        s_wide  = w;
        @(negedge sysclk);
    endtask

    logic [15:0] vals [6] = '{16'hA511, 16'h5A22, 16'hC333, 16'h0F44, 16'h1255, 16'h9966};
    logic [17:0] exp_q [$];

    initial begin
        int          n, cyc, n_acc;
        logic [15:0] v, ev;
        logic [1:0]  dcs;
        logic [5:0]  acc;
        logic [17:0] e;
        logic        a;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_tft_rst", tft_rst, 0);
        chk("rst_cs", tft_cs, 1);
        chk("rst_clk", tft_clk, 0);
        chk("rst_din", tft_din, 0);
        chk("rst_dc", tft_dc, 0);
        chk("rst_init", init_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", s_ready, 1);
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;

        n = 0;
        while (!tft_rst && n < 50) begin
            @(posedge sysclk); #1; n++;
        end
        chk("rst_low_len", n, 4);
        n = 0;
        while (!init_done && n < 50) begin
            @(posedge sysclk); #1; n++;
        end
        chk("rst_wait_len", n, 8);
        chk("cs_before_tx", tft_cs, 1);

        // Single command byte
        @(negedge sysclk);
        rise_t.delete();
        s_valid = 1'b1; s_data = 16'h002C; s_dc = 1'b0; s_wide = 1'b0;
        @(posedge sysclk); #1 s_valid = 1'b0;
        n = 0;
        while (tft_cs && n < 20) begin
            @(posedge sysclk); #1; n++;
        end
        chk("cs_latency", n, 2);
        n = 0;
        while (!tft_clk && n < 20) begin
            @(posedge sysclk); #1; n++;
        end
        chk("sck_latency", n, 2);
        chk("busy_tx", busy, 1);
        wait_idle();
        rx_take(8, v, dcs);
        chk("cmd_byte", v, 16'h002C);
        chk("cmd_dc", dcs, 2'b01);
        chk("cmd_pulses", rise_t.size(), 8);
        chk("sck_period", 32'(rise_t[1] - rise_t[0]), 40);
        chk("cs_idle", tft_cs, 1);

        // Two pixels back to back form one burst
        rise_t.delete();
        n = cs_falls;
        drive(16'hF81F, 1'b1, 1'b1);
        drive(16'h07E0, 1'b1, 1'b1);
        s_valid = 1'b0;
        wait_idle();
        chk("burst_cs_falls", cs_falls - n, 1);
        chk("burst_pulses", rise_t.size(), 32);
        chk("burst_intra", 32'(rise_t[1] - rise_t[0]), 40);
        chk("burst_inter", 32'(rise_t[16] - rise_t[15]), 50);
        rx_take(16, v, dcs);
        chk("px0", v, 16'hF81F);
        chk("px0_dc", dcs, 2'b10);
        rx_take(16, v, dcs);
        chk("px1", v, 16'h07E0);
        chk("px1_dc", dcs, 2'b10);

        // Reset in the middle of a shift
        drive(16'hFFFF, 1'b1, 1'b1);
        drive(16'hAAAA, 1'b0, 1'b1);
        s_valid = 1'b0;
        n = 0;
        while (rx_q.size() < 3 && n < 200) begin
            @(negedge sysclk); n++;
        end
        chk("mid_started", rx_q.size() >= 3, 1);
        chk("mid_pre_din", tft_din, 1);
        chk("mid_pre_level", fifo_level, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_tft_rst", tft_rst, 0);
        chk("mid_cs", tft_cs, 1);
        chk("mid_clk", tft_clk, 0);
        chk("mid_din", tft_din, 0);
        chk("mid_dc", tft_dc, 0);
        chk("mid_init", init_done, 0);
        chk("mid_busy", busy, 0);
        chk("mid_level", fifo_level, 0);
        repeat (3) @(negedge sysclk);
        rx_q.delete();
        rise_t.delete();
        rst_n = 1'b1;
        chk("restart_rst_low", tft_rst, 0);

        // Pre-queue six entries during the reset sequence into a 4-deep FIFO
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            acc[i] = s_ready;
            drive(vals[i], 1'(i % 2), 1'b0);
        end
        s_valid = 1'b0;
        chk("accept_mask", acc, 6'b001111);
        chk("full_ready", s_ready, 0);
        chk("full_level", fifo_level, 4);
        chk("held_until_init", init_done, 0);
        chk("held_cs", tft_cs, 1);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            rx_take(8, v, dcs);
            chk("preq_byte", v, {8'h00, vals[i][7:0]});
            chk("preq_dc", dcs, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        chk("preq_no_extra", rx_q.size(), 0);

        // Saturating random stream
        n_acc = 0;
        cyc = 0;
        while (n_acc < 40 && cyc < 8000) begin
            if (!s_valid) begin
                s_data  = 16'($urandom);
                s_dc    = 1'($urandom_range(0, 1));
                s_wide  = 1'($urandom_range(0, 1));
                s_valid = 1'b1;
            end
            a = s_ready;
            @(negedge sysclk);
            cyc++;
            if (a) begin
                exp_q.push_back({s_dc, s_wide, s_data});
                n_acc++;
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        chk("rnd_accepted", n_acc, 40);
        wait_idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rx_take(e[16] ? 16 : 8, v, dcs);
            ev = e[16] ? e[15:0] : {8'h00, e[7:0]};
            chk("rnd_data", v, ev);
            chk("rnd_dc", dcs, e[17] ? 2'b10 : 2'b01);
        end
        chk("rnd_no_extra", rx_q.size(), 0);
        chk("sck_while_cs_hi", sck_cs_hi, 0);
        chk("min_cs_gap", min_gap >= 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
